// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage memory access block.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_e;

    localparam int unsigned CTLM_BRANCH    = 2;
    localparam int unsigned CTLM_MEMREAD   = 1;
    localparam int unsigned CTLM_MEMWRITE  = 0;
    localparam int unsigned CTLWB_REGWRITE = 1;
    localparam int unsigned CTLWB_MEMTOREG = 0;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [XLEN-1:0]   rdata;
        logic [XLEN-1:0]   alu_out;
        logic [REG_AW-1:0] rd;
        logic [1:0]        ctlwb;
        logic              bus_err;
        logic              align_err;
    } wb_t;

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/ack bus between the MEM stage and the memory.
interface mem_access_if;
    import mem_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    logic            ack;

    modport master (output req, output we, output addr, output wdata,
                    input  rdata, input ack);
    modport slave  (input  req, input we, input addr, input wdata,
                    output rdata, output ack);
endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load enable and synchronous active-low reset.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  wb_t  d,
    output wb_t  q
);

    always_ff @(posedge clk) begin
        if (!rst_n)    q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: data-memory handshake FSM with timeout, branch resolve, WB register.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned accesses skip the bus and flag WB_align_err.
module mem_access
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   MEM_bpc,
    input  logic [XLEN-1:0]   MEM_alu_out,
    input  logic [XLEN-1:0]   MEM_rd2,
    input  logic [1:0]        MEM_ctlwb,
    input  logic [2:0]        MEM_ctlm,
    input  logic              MEM_alu_zero,
    input  logic [REG_AW-1:0] MEM_rd,
    mem_access_if.master      dmem,
    output logic              stall,
    output logic              pcsrc,
    output logic [XLEN-1:0]   pc_target,
    output logic [XLEN-1:0]   WB_rdata,
    output logic [XLEN-1:0]   WB_alu_out,
    output logic [REG_AW-1:0] WB_rd,
    output logic [1:0]        WB_ctlwb,
    output logic              WB_bus_err,
    output logic              WB_align_err
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d, we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d, align_err_q, align_err_d;
    logic              access, misalign, timeout, in_done;
    wb_t               wb_d, wb_q;

    assign access  = MEM_ctlm[CTLM_MEMREAD] | MEM_ctlm[CTLM_MEMWRITE];
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign in_done = (state_q == DONE);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = access & (|MEM_alu_out[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // State, counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            align_err_q <= align_err_d;
        end
    end

    // Next-state logic; ack beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (misalign)          state_d = DONE;
                      else if (access)       state_d = WAIT_ACK;
            WAIT_ACK: if (dmem.ack || timeout) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Next values of registered outputs and captured response.
    always_comb begin
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;
        align_err_d = align_err_q;
        unique case (state_q)
            IDLE: begin
                cnt_d       = '0;
                rdata_d     = '0;
                bus_err_d   = 1'b0;
                align_err_d = misalign;
                if (access && !misalign) begin
                    req_d   = 1'b1;
                    we_d    = MEM_ctlm[CTLM_MEMWRITE];
                    addr_d  = {MEM_alu_out[XLEN-1:2], 2'b00};
                    wdata_d = MEM_rd2;
                end
            end
            WAIT_ACK: begin
                if (dmem.ack) begin
                    req_d   = 1'b0;
                    rdata_d = we_q ? '0 : dmem.rdata;
                end else if (timeout) begin
                    req_d     = 1'b0;
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign stall     = ((state_q == IDLE) && access) || (state_q == WAIT_ACK);
    assign pcsrc     = MEM_ctlm[CTLM_BRANCH] & MEM_alu_zero;
    assign pc_target = MEM_bpc;

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    // WB payload: captured response only in DONE, otherwise a plain pass-through.
    always_comb begin
        wb_d.rdata     = in_done ? rdata_q : '0;
        wb_d.alu_out   = MEM_alu_out;
        wb_d.rd        = MEM_rd;
        wb_d.ctlwb     = {MEM_ctlwb[CTLWB_REGWRITE] & ~(in_done & (bus_err_q | align_err_q)),
                          MEM_ctlwb[CTLWB_MEMTOREG]};
        wb_d.bus_err   = in_done & bus_err_q;
        wb_d.align_err = in_done & align_err_q;
    end

    mem_wb_reg u_wb_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (~stall),
        .d     (wb_d),
        .q     (wb_q)
    );

    assign WB_rdata     = wb_q.rdata;
    assign WB_alu_out   = wb_q.alu_out;
    assign WB_rd        = wb_q.rd;
    assign WB_ctlwb     = wb_q.ctlwb;
    assign WB_bus_err   = wb_q.bus_err;
    assign WB_align_err = wb_q.align_err;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed instructions, queued WB expectations.
module tb_mem_access;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [1:0]  ctlwb;
        logic        bus_err;
        logic        align_err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] MEM_bpc = '0, MEM_alu_out = '0, MEM_rd2 = '0;
    logic [1:0]  MEM_ctlwb = '0;
    logic [2:0]  MEM_ctlm = '0;
    logic        MEM_alu_zero = 1'b0;
    logic [4:0]  MEM_rd = '0;
    logic        stall, pcsrc;
    logic [31:0] pc_target, WB_rdata, WB_alu_out;
    logic [4:0]  WB_rd;
    logic [1:0]  WB_ctlwb;
    logic        WB_bus_err, WB_align_err;

    mem_access_if dmem_if ();

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_bpc(MEM_bpc), .MEM_alu_out(MEM_alu_out), .MEM_rd2(MEM_rd2),
        .MEM_ctlwb(MEM_ctlwb), .MEM_ctlm(MEM_ctlm), .MEM_alu_zero(MEM_alu_zero),
        .MEM_rd(MEM_rd), .dmem(dmem_if),
        .stall(stall), .pcsrc(pcsrc), .pc_target(pc_target),
        .WB_rdata(WB_rdata), .WB_alu_out(WB_alu_out), .WB_rd(WB_rd),
        .WB_ctlwb(WB_ctlwb), .WB_bus_err(WB_bus_err), .WB_align_err(WB_align_err)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0, n_fail = 0;
    exp_t exp_q[$];
    logic instr_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: ack in the ack_after-th request cycle (0 = never).
    int          ack_after = 0, req_cycles = 0;
    logic [31:0] mem_rdata = '0, cap_addr = '0, cap_wdata = '0;
    logic        cap_we = 1'b0, stable_ok = 1'b1, req_seen = 1'b0, ack_force = 1'b0;

    initial begin
        dmem_if.ack   = 1'b0;
        dmem_if.rdata = '0;
    end

    always @(posedge clk) begin
        #1;
        if (dmem_if.req) begin
            req_cycles++;
            req_seen = 1'b1;
            if (req_cycles == 1) begin
                cap_addr  = dmem_if.addr;
                cap_we    = dmem_if.we;
                cap_wdata = dmem_if.wdata;
                stable_ok = 1'b1;
            end else if (dmem_if.addr !== cap_addr || dmem_if.we !== cap_we ||
                         dmem_if.wdata !== cap_wdata) begin
                stable_ok = 1'b0;
            end
        end else begin
            req_cycles = 0;
        end
        dmem_if.ack   = (dmem_if.req && ack_after != 0 && req_cycles == ack_after) || ack_force;
        dmem_if.rdata = mem_rdata;
    end

    // Monitor: a WB load happens on each edge after a stall-free cycle of a live instruction.
    logic load_pending = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (load_pending) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("WB_rdata",     WB_rdata,            e.rdata);
                check("WB_alu_out",   WB_alu_out,          e.alu);
                check("WB_rd",        32'(WB_rd),          32'(e.rd));
                check("WB_ctlwb",     32'(WB_ctlwb),       32'(e.ctlwb));
                check("WB_bus_err",   32'(WB_bus_err),     32'(e.bus_err));
                check("WB_align_err", 32'(WB_align_err),   32'(e.align_err));
            end
        end
        load_pending = instr_valid && !stall;
    end

    // Present one instruction, hold it until stall drops, report stalled cycles.
    task automatic issue(input logic [2:0] ctlm, input logic [1:0] ctlwb,
                         input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [4:0] rd, input logic [31:0] bpc, input logic zero,
                         input int ackn, input logic [31:0] rdata, input exp_t e,
                         output int stalls);
        int budget;
        @(posedge clk); #1;
        MEM_ctlm = ctlm; MEM_ctlwb = ctlwb; MEM_alu_out = alu; MEM_rd2 = rd2;
        MEM_rd = rd; MEM_bpc = bpc; MEM_alu_zero = zero;
        ack_after = ackn; mem_rdata = rdata; req_seen = 1'b0;
        instr_valid = 1'b1;
        exp_q.push_back(e);
        stalls = 0;
        budget = 50;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            budget--;
            if (budget == 0) begin
                check("stall_bound", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    initial begin
        int   s;
        exp_t e;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req",      32'(dmem_if.req), 32'd0);
        check("rst_we",       32'(dmem_if.we),  32'd0);
        check("rst_addr",     dmem_if.addr,     32'd0);
        check("rst_wdata",    dmem_if.wdata,    32'd0);
        check("rst_WB_rdata", WB_rdata,         32'd0);
        check("rst_WB_alu",   WB_alu_out,       32'd0);
        check("rst_WB_ctlwb", 32'(WB_ctlwb),    32'd0);
        check("rst_stall",    32'(stall),       32'd0);

        // ALU op passes through in one cycle
        e = '{32'h0, 32'h0000_1234, 5'd5, 2'b10, 1'b0, 1'b0};
        issue(3'b000, 2'b10, 32'h1234, 32'h0, 5'd5, 32'h0, 1'b0, 0, 32'h0, e, s);
        check("alu_stalls", 32'(s), 32'd0);

        // Load, ack in the 3rd WAIT_ACK cycle
        e = '{32'hDEAD_BEEF, 32'h10, 5'd7, 2'b11, 1'b0, 1'b0};
        issue(3'b010, 2'b11, 32'h10, 32'h0, 5'd7, 32'h0, 1'b0, 3, 32'hDEAD_BEEF, e, s);
        check("ld_stalls", 32'(s), 32'd4);
        check("ld_addr",   cap_addr, 32'h10);
        check("ld_we",     32'(cap_we), 32'd0);
        check("ld_stable", 32'(stable_ok), 32'd1);

        // Store, ack in 1 cycle; stored data never reaches WB_rdata
        e = '{32'h0, 32'h20, 5'd0, 2'b00, 1'b0, 1'b0};
        issue(3'b001, 2'b00, 32'h20, 32'h1234_5678, 5'd0, 32'h0, 1'b0, 1, 32'hFFFF_FFFF, e, s);
        check("st_stalls", 32'(s), 32'd2);
        check("st_addr",   cap_addr, 32'h20);
        check("st_wdata",  cap_wdata, 32'h1234_5678);
        check("st_we",     32'(cap_we), 32'd1);
        check("st_stable", 32'(stable_ok), 32'd1);

        // Timeout after 4 WAIT_ACK cycles: bus error, regwrite squashed
        e = '{32'h0, 32'h30, 5'd3, 2'b01, 1'b1, 1'b0};
        issue(3'b010, 2'b11, 32'h30, 32'h0, 5'd3, 32'h0, 1'b0, 0, 32'hAAAA_AAAA, e, s);
        check("to_stalls", 32'(s), 32'd5);

        // Ack on the 4th cycle beats the timeout
        e = '{32'hCAFE_F00D, 32'h34, 5'd4, 2'b11, 1'b0, 1'b0};
        issue(3'b010, 2'b11, 32'h34, 32'h0, 5'd4, 32'h0, 1'b0, 4, 32'hCAFE_F00D, e, s);
        check("late_ack_stalls", 32'(s), 32'd5);

        // Branch taken resolves combinationally without stalling
        e = '{32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0};
        issue(3'b100, 2'b00, 32'h0, 32'h0, 5'd0, 32'h400, 1'b1, 0, 32'h0, e, s);
        check("br_pcsrc",  32'(pcsrc), 32'd1);
        check("br_target", pc_target, 32'h400);
        check("br_stalls", 32'(s), 32'd0);

        e = '{32'h0, 32'h1, 5'd0, 2'b00, 1'b0, 1'b0};
        issue(3'b100, 2'b00, 32'h1, 32'h0, 5'd0, 32'h800, 1'b0, 0, 32'h0, e, s);
        check("br_nt_pcsrc",  32'(pcsrc), 32'd0);
        check("br_nt_target", pc_target, 32'h800);

        // Misaligned load at 0x13
`ifdef MEM_ALIGN_CHECK_EN
        e = '{32'h0, 32'h13, 5'd9, 2'b01, 1'b0, 1'b1};
        issue(3'b010, 2'b11, 32'h13, 32'h0, 5'd9, 32'h0, 1'b0, 1, 32'h5555_5555, e, s);
        check("mis_stalls", 32'(s), 32'd1);
        check("mis_no_req", 32'(req_seen), 32'd0);
`else
        e = '{32'h5555_5555, 32'h13, 5'd9, 2'b11, 1'b0, 1'b0};
        issue(3'b010, 2'b11, 32'h13, 32'h0, 5'd9, 32'h0, 1'b0, 1, 32'h5555_5555, e, s);
        check("mis_stalls", 32'(s), 32'd2);
        check("mis_addr",   cap_addr, 32'h10);
`endif

        // Reset during WAIT_ACK abandons the access; a late ack is ignored
        @(posedge clk); #1;
        instr_valid = 1'b0;
        MEM_ctlm = 3'b010; MEM_ctlwb = 2'b11; MEM_alu_out = 32'h40; MEM_rd = 5'd1;
        ack_after = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        MEM_ctlm = '0; MEM_ctlwb = '0; MEM_alu_out = '0; MEM_rd = '0;
        @(negedge clk);
        check("rw_req",      32'(dmem_if.req), 32'd0);
        check("rw_WB_rdata", WB_rdata,         32'd0);
        check("rw_WB_alu",   WB_alu_out,       32'd0);
        check("rw_WB_rd",    32'(WB_rd),       32'd0);
        check("rw_WB_ctlwb", 32'(WB_ctlwb),    32'd0);
        check("rw_WB_err",   32'({WB_bus_err, WB_align_err}), 32'd0);
        ack_force = 1'b1;
        @(negedge clk);
        ack_force = 1'b0;
        repeat (2) @(negedge clk);
        check("rw_ack_stall",  32'(stall),       32'd0);
        check("rw_ack_req",    32'(dmem_if.req), 32'd0);
        check("rw_ack_rdata",  WB_rdata,         32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum number of WAIT_ACK cycles before an access is aborted (range 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have inputs MEM_bpc/MEM_alu_out/MEM_rd2  input  32 each  branch target, address or ALU result, store data.
REQ-005 SHALL have inputs MEM_ctlwb  input  2  {regwrite, memtoreg}; MEM_ctlm  input  3  {branch, memread, memwrite}; MEM_alu_zero  input  1; MEM_rd  input  5.
REQ-006 SHALL have data-memory ports dmem_req  output  1; dmem_we  output  1; dmem_addr  output  32; dmem_wdata  output  32; dmem_rdata  input  32; dmem_ack  input  1.
REQ-007 SHALL have outputs stall  output  1; pcsrc  output  1; pc_target  output  32.
REQ-008 SHALL have WB outputs WB_rdata  32; WB_alu_out  32; WB_rd  5; WB_ctlwb  2; WB_bus_err  1; WB_align_err  1; all are outputs.

Function
REQ-009 SHALL implement states IDLE, WAIT_ACK, DONE.
REQ-010 An access is memread|memwrite; if both are set, it SHALL be a write.
REQ-011 IDLE with an access pending: SHALL go to WAIT_ACK and register dmem_req=1, dmem_we, dmem_addr, dmem_wdata=MEM_rd2, which are valid from the next cycle.
REQ-012 dmem_addr, dmem_we, and dmem_wdata SHALL hold stable while dmem_req=1.
REQ-013 WAIT_ACK with dmem_ack=1: SHALL capture dmem_rdata (reads only), deassert dmem_req on the next edge, and go to DONE.
REQ-014 The cycle counter SHALL clear on entry to WAIT_ACK and increment each WAIT_ACK cycle without ack.
REQ-015 At count == TIMEOUT_CYCLES-1 without ack: SHALL go to DONE with WB_bus_err=1, rdata=0, and regwrite squashed.
REQ-016 A dmem_ack arriving in the same cycle as the timeout SHALL win; no error is raised.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE; dmem_ack seen outside WAIT_ACK SHALL be ignored.
REQ-018 stall SHALL = (IDLE & access pending) | WAIT_ACK, combinational; stall SHALL = 0 in DONE.
REQ-019 WB_* registers SHALL load on every edge where stall=0, taking MEM_alu_out, MEM_rd, MEM_ctlwb, captured rdata, and error flags; error flags SHALL be 0 for non-access instructions.
REQ-020 Minimum load latency: request in cycle N, ack in N+1, DONE in N+2, WB_rdata valid at N+3.
REQ-021 Non-memory instructions SHALL pass to WB with 1-cycle latency.
REQ-022 pcsrc SHALL = branch & MEM_alu_zero, combinational; pc_target SHALL = MEM_bpc.
REQ-023 Writes SHALL never update WB_rdata; WB_rdata SHALL be 0 for writes and non-memory instructions.

Reset
REQ-024 rst_n=0 at a rising edge SHALL force: state IDLE, counter 0, dmem_req/dmem_we 0, dmem_addr/dmem_wdata 0, and all WB_* outputs 0.
REQ-025 Reset asserted in WAIT_ACK SHALL abandon the access; dmem_req SHALL be 0 after that edge and a late ack SHALL be ignored.

Configuration
REQ-026 With MEM_ALIGN_CHECK_EN defined: an access with addr[1:0]!=0 SHALL issue no dmem_req, SHALL go IDLE->DONE, and SHALL set WB_align_err=1 with regwrite squashed; stall SHALL be 1 for that one IDLE cycle.
REQ-027 Without MEM_ALIGN_CHECK_EN: dmem_addr[1:0] SHALL be forced to 0 and WB_align_err SHALL be tied 0.

Structure
REQ-028 Package mem_pkg SHALL hold the state enum, MEM_ctlm/MEM_ctlwb bit-index constants, and the counter width.
REQ-029 The WB output register SHALL be a sub-module, mem_wb_reg, with a load enable; the FSM and counter SHALL stay in mem_access.

Verification
REQ-030 Load: addr 0x10, ack after 3 cycles, rdata 0xDEADBEEF -> stall high 4 cycles, WB_rdata=0xDEADBEEF, WB_ctlwb=2'b11.
REQ-031 Store: addr 0x20, data 0x12345678, ack in 1 cycle -> dmem_we=1 with addr/data stable while req; WB_rdata=0.
REQ-032 No ack, TIMEOUT_CYCLES=4 -> DONE after 4 WAIT_ACK cycles, WB_bus_err=1, WB_ctlwb[1]=0; ack arriving on the 4th cycle -> no error.
REQ-033 Branch with zero=1, bpc=0x400 -> pcsrc=1 and pc_target=0x400 in the same cycle, stall=0.
REQ-034 rst_n low during WAIT_ACK -> dmem_req=0 next cycle, all WB_*=0, and a later ack causes no state change.
REQ-035 With MEM_ALIGN_CHECK_EN, load addr 0x13 -> no dmem_req, WB_align_err=1; without the macro -> dmem_addr=0x10.
